// File: rtl/spike_pkg.sv
// Shared types and width helpers for the spike-time frame builder.
package spike_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } fsm_state_t;

    // Width of the one-hot shift magnitude for a range of +/-max_shift_mag.
    function automatic int unsigned shift_w(input int unsigned max_shift_mag);
        return 2 * max_shift_mag + 1;
    endfunction

    // Time-step counter width, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/spike_out_slot.sv
// One-entry valid/ready output register for {frame, shift_mag} with sticky drop flag.
module spike_out_slot
    import spike_pkg::*;
#(
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned MAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [0:FRAME_W-1] frame_i,
    input  logic [0:MAG_W-1]   shift_mag_i,
    input  logic             ready_i,
    output logic [0:FRAME_W-1] frame_o,
    output logic [0:MAG_W-1]   shift_mag_o,
    output logic             valid_o,
    output logic             overflow_o
);

    logic accept_c;
    logic can_load_c;
    logic drop_c;

    // A draining slot can be refilled in the same cycle, so no bubble appears.
    assign accept_c   = valid_o && ready_i;
    assign can_load_c = !valid_o || accept_c;
    assign drop_c     = load_i && !can_load_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o     <= 1'b0;
            frame_o     <= '0;
            shift_mag_o <= '0;
            overflow_o  <= 1'b0;
        end else begin
            if (load_i && can_load_c) begin
                valid_o     <= 1'b1;
                frame_o     <= frame_i;
                shift_mag_o <= shift_mag_i;
            end else if (accept_c) begin
                valid_o <= 1'b0;
            end
            if (drop_c) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_frame_builder.sv
// Samples a serial spike line over LEN ticks into a frame and hands it, with
// its shift magnitude, to a one-entry valid/ready output slot.
module spike_frame_builder
    import spike_pkg::*;
#(
    parameter int unsigned LEN              = 8,
    parameter int unsigned MAX_SHIFT_MAG    = 2,
    parameter int unsigned FIRST_SPIKE_ONLY = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start_i,
    input  logic                            tick_i,
    input  logic                            spike_i,
    input  logic [0:2*MAX_SHIFT_MAG]        shift_mag_i,
    output logic [0:LEN-1]                  frame_o,
    output logic [0:2*MAX_SHIFT_MAG]        shift_mag_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            overflow_o,
    output logic                            busy_o
);

    localparam int unsigned SHIFT_W = shift_w(MAX_SHIFT_MAG);
    localparam int unsigned CNT_W   = cnt_w(LEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(LEN - 1);

    fsm_state_t         state_q;
    fsm_state_t         next_state;
    logic [CNT_W-1:0]   cnt_q;
    logic [0:LEN-1]     cap_q;
    logic [0:SHIFT_W-1] mag_q;

    logic               last_c;
    logic               clear_c;
    logic               step_c;
    logic               done_c;
    logic               write_en_c;
    logic [0:LEN-1]     frame_next_c;

    assign last_c = (cnt_q == LAST_STEP);

    // In first-spike mode a frame keeps only its earliest spike.
    assign write_en_c = spike_i && !((FIRST_SPIKE_ONLY != 0) && (|cap_q));

    always_comb begin
        frame_next_c = cap_q;
        for (int i = 0; i < int'(LEN); i++) begin
            if (write_en_c && (cnt_q == CNT_W'(i))) begin
                frame_next_c[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // The final tick completes the old frame even when a restart arrives with it.
    always_comb begin
        next_state = state_q;
        clear_c    = 1'b0;
        step_c     = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    clear_c    = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (tick_i && last_c) begin
                    done_c = 1'b1;
                    if (frame_start_i) begin
                        clear_c = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (frame_start_i) begin
                    clear_c = 1'b1;
                end else if (tick_i) begin
                    step_c = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            cap_q <= '0;
            mag_q <= '0;
        end else if (clear_c) begin
            cnt_q <= '0;
            cap_q <= '0;
            mag_q <= shift_mag_i;
        end else if (step_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            cap_q <= frame_next_c;
        end
    end

    assign busy_o = (state_q == CAPTURE);

    spike_out_slot #(
        .FRAME_W (LEN),
        .MAG_W   (SHIFT_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (done_c),
        .frame_i     (frame_next_c),
        .shift_mag_i (mag_q),
        .ready_i     (ready_i),
        .frame_o     (frame_o),
        .shift_mag_o (shift_mag_o),
        .valid_o     (valid_o),
        .overflow_o  (overflow_o)
    );

endmodule

// File: tb/tb_spike_frame_builder.sv
// Bench for spike_frame_builder: union and first-spike instances share stimulus
// and are checked against an event-level model of frames and the output slot.
module tb_spike_frame_builder;

    localparam int LEN = 8;

    logic clk;
    logic rst;
    logic frame_start;
    logic tick;
    logic spike;
    logic ready;
    logic [0:4] smag_in;

    logic [0:LEN-1] frame_a, frame_f;
    logic [0:4]     smag_a, smag_f;
    logic           valid_a, valid_f, ovf_a, ovf_f, busy_a, busy_f;

    int errors;
    int checks;

    // Reference model state.
    logic           m_cap;
    int             m_t;
    int             m_spikes[$];
    logic [0:4]     m_mag;
    logic           m_valid;
    logic [0:LEN-1] m_fa, m_ff;
    logic [0:4]     m_smag;
    logic           m_ovf;

    spike_frame_builder #(.LEN(LEN), .MAX_SHIFT_MAG(2), .FIRST_SPIKE_ONLY(0)) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start), .tick_i(tick),
        .spike_i(spike), .shift_mag_i(smag_in), .frame_o(frame_a),
        .shift_mag_o(smag_a), .valid_o(valid_a), .ready_i(ready),
        .overflow_o(ovf_a), .busy_o(busy_a)
    );

    spike_frame_builder #(.LEN(LEN), .MAX_SHIFT_MAG(2), .FIRST_SPIKE_ONLY(1)) dut_fs (
        .clk(clk), .rst(rst), .frame_start_i(frame_start), .tick_i(tick),
        .spike_i(spike), .shift_mag_i(smag_in), .frame_o(frame_f),
        .shift_mag_o(smag_f), .valid_o(valid_f), .ready_i(ready),
        .overflow_o(ovf_f), .busy_o(busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:LEN-1] frame_of(input int q[$], input bit first);
        logic [0:LEN-1] f;
        int earliest;
        f = '0;
        if (first) begin
            if (q.size() > 0) begin
                earliest = q[0];
                foreach (q[k]) if (q[k] < earliest) earliest = q[k];
                f[earliest] = 1'b1;
            end
        end else begin
            foreach (q[k]) f[q[k]] = 1'b1;
        end
        return f;
    endfunction

    task automatic model_update();
        bit emit;
        logic [0:LEN-1] fa, ff;
        logic [0:4] em;
        emit = 0;
        fa = '0;
        ff = '0;
        em = '0;
        if (rst) begin
            m_cap = 0; m_t = 0; m_spikes.delete(); m_mag = '0;
            m_valid = 0; m_fa = '0; m_ff = '0; m_smag = '0; m_ovf = 0;
            return;
        end
        if (m_cap && tick && m_t == LEN - 1) begin
            if (spike) m_spikes.push_back(m_t);
            emit = 1;
            fa = frame_of(m_spikes, 0);
            ff = frame_of(m_spikes, 1);
            em = m_mag;
            if (frame_start) begin
                m_t = 0; m_spikes.delete(); m_mag = smag_in;
            end else begin
                m_cap = 0;
            end
        end else if (frame_start) begin
            m_cap = 1; m_t = 0; m_spikes.delete(); m_mag = smag_in;
        end else if (m_cap && tick) begin
            if (spike) m_spikes.push_back(m_t);
            m_t++;
        end
        if (emit) begin
            if (!m_valid || ready) begin
                m_valid = 1; m_fa = fa; m_ff = ff; m_smag = em;
            end else begin
                m_ovf = 1;
            end
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; frame_start = 0; tick = 0; spike = 0; ready = 0; smag_in = '0;
        step(); step();
        checks++; if (valid_a !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", valid_a); end
        checks++; if (frame_a !== 8'h00) begin errors++; $display("FAIL reset_frame got %b exp 0", frame_a); end
        checks++; if (smag_a !== 5'b0)   begin errors++; $display("FAIL reset_smag got %b exp 0", smag_a); end
        checks++; if ({ovf_a, busy_a, ovf_f, busy_f, valid_f} !== 5'b0)
            begin errors++; $display("FAIL reset_flags got %b exp 00000", {ovf_a, busy_a, ovf_f, busy_f, valid_f}); end
        rst = 0;
        step();
    endtask

    task automatic test_basic();
        ready = 1;
        frame_start = 1; smag_in = 5'b00010; step();
        frame_start = 0;
        for (int t = 0; t < LEN; t++) begin
            tick = 1; spike = (t == 1 || t == 6); step();
        end
        tick = 0; spike = 0;
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", valid_a); end
        checks++; if (frame_a !== 8'b0100_0010) begin errors++; $display("FAIL basic_frame got %b exp 01000010", frame_a); end
        checks++; if (frame_a !== m_fa) begin errors++; $display("FAIL basic_frame_model got %b exp %b", frame_a, m_fa); end
        checks++; if (smag_a !== 5'b00010) begin errors++; $display("FAIL basic_smag got %b exp 00010", smag_a); end
        checks++; if (frame_f !== 8'b0100_0000) begin errors++; $display("FAIL first_spike_frame got %b exp 01000000", frame_f); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy_a); end
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b exp 0", valid_a); end
    endtask

    task automatic test_backpressure();
        ready = 0;
        frame_start = 1; smag_in = 5'b00100; step();
        frame_start = 0;
        for (int t = 0; t < LEN; t++) begin
            tick = 1; spike = 1;
            frame_start = (t == LEN - 1); smag_in = 5'b01000;
            step();
        end
        frame_start = 0;
        checks++; if (frame_a !== 8'hFF || valid_a !== 1'b1)
            begin errors++; $display("FAIL bp_first_frame got %b/%b exp 11111111/1", frame_a, valid_a); end
        for (int t = 0; t < LEN; t++) begin
            tick = 1; spike = (t == LEN - 1); step();
        end
        tick = 0; spike = 0;
        checks++; if (frame_a !== 8'hFF) begin errors++; $display("FAIL bp_hold_frame got %b exp 11111111", frame_a); end
        checks++; if (smag_a !== 5'b00100) begin errors++; $display("FAIL bp_hold_smag got %b exp 00100", smag_a); end
        checks++; if (ovf_a !== 1'b1 || ovf_f !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b%b exp 11", ovf_a, ovf_f); end
        ready = 1; step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", valid_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b exp 1", ovf_a); end
    endtask

    task automatic test_restart();
        ready = 1;
        frame_start = 1; smag_in = 5'b00001; step();
        frame_start = 0;
        for (int t = 0; t < LEN; t++) begin
            tick = 1; spike = (t == LEN - 1);
            frame_start = (t == LEN - 1); smag_in = 5'b10000;
            step();
        end
        frame_start = 0;
        checks++; if (frame_a !== 8'b0000_0001 || valid_a !== 1'b1)
            begin errors++; $display("FAIL restart_frame got %b/%b exp 00000001/1", frame_a, valid_a); end
        checks++; if (smag_a !== 5'b00001) begin errors++; $display("FAIL restart_old_smag got %b exp 00001", smag_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", busy_a); end
        for (int t = 0; t < LEN; t++) begin
            tick = 1; spike = (t == 0); step();
        end
        tick = 0; spike = 0;
        checks++; if (frame_a !== 8'b1000_0000) begin errors++; $display("FAIL restart_next_frame got %b exp 10000000", frame_a); end
        checks++; if (smag_a !== 5'b10000) begin errors++; $display("FAIL restart_new_smag got %b exp 10000", smag_a); end
        step();
    endtask

    task automatic test_abort();
        int outputs;
        logic [0:LEN-1] seen;
        outputs = 0; seen = '0;
        ready = 1;
        frame_start = 1; smag_in = 5'b00100; step();
        frame_start = 0;
        for (int t = 0; t < 3; t++) begin
            tick = 1; spike = 1; step();
            if (valid_a) begin outputs++; seen = frame_a; end
        end
        tick = 0; frame_start = 1; spike = 0; step();
        if (valid_a) begin outputs++; seen = frame_a; end
        frame_start = 0;
        for (int t = 0; t < LEN + 4; t++) begin
            tick = (t < LEN); spike = (t == 2); step();
            if (valid_a) begin outputs++; seen = frame_a; end
        end
        tick = 0; spike = 0;
        checks++; if (outputs != 1) begin errors++; $display("FAIL abort_count got %0d exp 1", outputs); end
        checks++; if (seen !== 8'b0010_0000) begin errors++; $display("FAIL abort_frame got %b exp 00100000", seen); end
    endtask

    task automatic test_reset_mid();
        int outputs;
        outputs = 0;
        ready = 1;
        frame_start = 1; smag_in = 5'b00010; step();
        frame_start = 0;
        for (int t = 0; t < 4; t++) begin
            tick = 1; spike = 1; step();
        end
        tick = 0; rst = 1; step();
        checks++; if ({valid_a, ovf_a, busy_a} !== 3'b000 || frame_a !== 8'h00 || smag_a !== 5'b0)
            begin errors++; $display("FAIL midreset_outputs got %b %b %b exp 000 0 0", {valid_a, ovf_a, busy_a}, frame_a, smag_a); end
        rst = 0;
        for (int t = 0; t < 12; t++) begin
            tick = 1; spike = 1; step();
            if (valid_a || busy_a) outputs++;
        end
        tick = 0; spike = 0;
        checks++; if (outputs != 0) begin errors++; $display("FAIL ticks_without_start got %0d exp 0", outputs); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            frame_start = ($urandom_range(0, 11) == 0);
            tick        = ($urandom_range(0, 1) == 1);
            spike       = ($urandom_range(0, 2) == 0);
            ready       = ($urandom_range(0, 9) < 7);
            smag_in     = 5'($urandom);
            step();
            checks++;
            if ({valid_a, valid_f} !== {m_valid, m_valid} || {busy_a, busy_f} !== {m_cap, m_cap}
                || {ovf_a, ovf_f} !== {m_ovf, m_ovf}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d got v%b%b b%b%b o%b%b exp v%b b%b o%b", n,
                         valid_a, valid_f, busy_a, busy_f, ovf_a, ovf_f, m_valid, m_cap, m_ovf);
            end
            checks++;
            if (frame_a !== m_fa || frame_f !== m_ff || smag_a !== m_smag || smag_f !== m_smag) begin
                errors++;
                $display("FAIL rand_data cyc %0d got %b %b %b exp %b %b %b", n,
                         frame_a, frame_f, smag_a, m_fa, m_ff, m_smag);
            end
        end
        rst = 0; frame_start = 0; tick = 0; spike = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_cap = 0; m_t = 0; m_mag = '0; m_valid = 0;
        m_fa = '0; m_ff = '0; m_smag = '0; m_ovf = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_restart();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
